io_in_filter: RTL and testbench



---
 rtl/io_in_filter_if.sv | 23 ++
 rtl/io_in_filter.sv | 104 ++++++++++
 tb/tb_io_in_filter.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/io_in_filter_if.sv
// Pad-side and consumer-side signals of io_in_filter, grouped per instance.
// The driver of the raw pads and flag clears uses master; the filter uses slave.
interface io_in_filter_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] pad;
  logic [WIDTH-1:0] ev_clr;
  logic [WIDTH-1:0] val;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic [WIDTH-1:0] ev_rise;
  logic [WIDTH-1:0] ev_fall;

  modport master (
    output pad, ev_clr,
    input  val, rise, fall, ev_rise, ev_fall
  );

  modport slave (
    input  pad, ev_clr,
    output val, rise, fall, ev_rise, ev_fall
  );
endinterface

// File: rtl/io_in_filter.sv
// Multi-channel pad conditioner: per-channel synchroniser, consecutive-sample
// glitch filter, registered rise/fall pulses and sticky, clearable edge flags.
module io_in_filter #(
  parameter int               WIDTH       = 3,
  parameter int               SYNC_STAGES = 2,
  parameter int               FILTER_LEN  = 1,
  parameter logic [WIDTH-1:0] RESET_VAL   = '0
) (
  input  logic           clk,
  input  logic           reset_n,
  io_in_filter_if.slave  bus
);

  localparam int               CNT_W    = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [WIDTH-1:0]            sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]            samp;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]            val_q, val_d;
  logic [WIDTH-1:0]            rise_q, rise_d;
  logic [WIDTH-1:0]            fall_q, fall_d;
  logic [WIDTH-1:0]            ev_rise_q, ev_rise_d;
  logic [WIDTH-1:0]            ev_fall_q, ev_fall_d;

  // NOTE: the chain is reset to RESET_VAL (not left unreset like a RAM) so a
  // pad held at its idle level through reset release never looks like an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= RESET_VAL;
    end else begin
      // NOTE: non-blocking assignments make every stage take its neighbour's
      // old value, which is what turns this loop into a shift register.
      sync_q[0] <= bus.pad;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign samp = sync_q[SYNC_STAGES-1];

  // A channel flips only after FILTER_LEN consecutive samples disagree with
  // val; any agreeing sample in between throws the partial count away.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch forms
    // on the paths where a channel is idle.
    val_d  = val_q;
    rise_d = '0;
    fall_d = '0;
    cnt_d  = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (samp[i] != val_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          val_d[i]  = samp[i];
          rise_d[i] = samp[i];
          fall_d[i] = ~samp[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Set beats clear, so a pulse arriving with a clear is never lost.
  assign ev_rise_d = rise_q | (ev_rise_q & ~bus.ev_clr);
  assign ev_fall_d = fall_q | (ev_fall_q & ~bus.ev_clr);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q     <= '0;
      val_q     <= RESET_VAL;
      rise_q    <= '0;
      fall_q    <= '0;
      ev_rise_q <= '0;
      ev_fall_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      val_q     <= val_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      ev_rise_q <= ev_rise_d;
      ev_fall_q <= ev_fall_d;
    end
  end

  assign bus.val     = val_q;
  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.ev_rise = ev_rise_q;
  assign bus.ev_fall = ev_fall_q;

`ifndef SYNTHESIS
  a_rise_fall_excl : assert property (@(posedge clk) disable iff (!reset_n)
    (rise_q & fall_q) == '0);

  a_pulse_matches_level : assert property (@(posedge clk) disable iff (!reset_n)
    ((rise_q & ~val_q) | (fall_q & val_q)) == '0);

  for (genvar g = 0; g < WIDTH; g++) begin : g_cnt_chk
    a_cnt_bounded : assert property (@(posedge clk) disable iff (!reset_n)
      cnt_q[g] <= CNT_LAST);
  end
`endif

endmodule

// File: tb/tb_io_in_filter.sv
// Bench for io_in_filter: two instances (unfiltered and FILTER_LEN=4) driven by
// directed and random pad activity, scored against a per-edge behavioural model.
`timescale 1ns/1ps
module tb_io_in_filter;

  localparam logic [2:0] RV_A = 3'b100;
  localparam logic [2:0] RV_B = 3'b000;
  localparam int         S_A  = 2;
  localparam int         F_A  = 1;
  localparam int         S_B  = 2;
  localparam int         F_B  = 4;

  typedef struct packed {
    logic [2:0] val;
    logic [2:0] rise;
    logic [2:0] fall;
    logic [2:0] evr;
    logic [2:0] evf;
  } obs_t;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  io_in_filter_if #(.WIDTH(3)) bus_a ();
  io_in_filter_if #(.WIDTH(3)) bus_b ();

  io_in_filter #(.WIDTH(3), .SYNC_STAGES(S_A), .FILTER_LEN(F_A), .RESET_VAL(RV_A)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  io_in_filter #(.WIDTH(3), .SYNC_STAGES(S_B), .FILTER_LEN(F_B), .RESET_VAL(RV_B)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // q is simply the pad as applied SYNC_STAGES edges ago (reset level before
  // that); val flips once q has disagreed with it on FILTER_LEN edges in a row.
  logic [2:0] m_val [2];
  logic [2:0] m_rise[2];
  logic [2:0] m_fall[2];
  logic [2:0] m_evr [2];
  logic [2:0] m_evf [2];
  int         m_run [2][3];
  logic [2:0] m_hist[2][64];
  int         m_n   [2];
  int         m_rise_cnt[2][3];

  function automatic logic [2:0] rv_of(input int d);
    return (d == 0) ? RV_A : RV_B;
  endfunction

  task automatic model_reset(input int d);
    m_val[d]  = rv_of(d);
    m_rise[d] = '0;
    m_fall[d] = '0;
    m_evr[d]  = '0;
    m_evf[d]  = '0;
    m_n[d]    = 0;
    for (int i = 0; i < 3; i++) m_run[d][i] = 0;
  endtask

  task automatic model_step(input int d, input logic [2:0] p, input logic [2:0] c);
    logic [2:0] q;
    int s;
    int f;
    s = (d == 0) ? S_A : S_B;
    f = (d == 0) ? F_A : F_B;
    q = (m_n[d] >= s) ? m_hist[d][(m_n[d] - s) % 64] : rv_of(d);
    m_evr[d]  = m_rise[d] | (m_evr[d] & ~c);
    m_evf[d]  = m_fall[d] | (m_evf[d] & ~c);
    m_rise[d] = '0;
    m_fall[d] = '0;
    for (int i = 0; i < 3; i++) begin
      if (q[i] !== m_val[d][i]) begin
        m_run[d][i]++;
        if (m_run[d][i] == f) begin
          m_val[d][i]  = q[i];
          m_rise[d][i] = q[i];
          m_fall[d][i] = ~q[i];
          m_run[d][i]  = 0;
          if (q[i]) m_rise_cnt[d][i]++;
        end
      end else begin
        m_run[d][i] = 0;
      end
    end
    m_hist[d][m_n[d] % 64] = p;
    m_n[d]++;
  endtask

  function automatic obs_t model_obs(input int d);
    obs_t o;
    o.val  = m_val[d];
    o.rise = m_rise[d];
    o.fall = m_fall[d];
    o.evr  = m_evr[d];
    o.evf  = m_evf[d];
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  obs_t exp_a[$];
  obs_t exp_b[$];
  obs_t e_a, e_b, o_a, o_b;
  int   dut_rise_cnt[2][3];

  always @(posedge clk) begin
    #1;
    o_a = {bus_a.val, bus_a.rise, bus_a.fall, bus_a.ev_rise, bus_a.ev_fall};
    o_b = {bus_b.val, bus_b.rise, bus_b.fall, bus_b.ev_rise, bus_b.ev_fall};
    for (int i = 0; i < 3; i++) begin
      if (bus_a.rise[i]) dut_rise_cnt[0][i]++;
      if (bus_b.rise[i]) dut_rise_cnt[1][i]++;
    end
    if (exp_a.size() > 0) begin
      e_a = exp_a.pop_front();
      check("sb_a{val,rise,fall,evr,evf}", 32'(o_a), 32'(e_a));
    end
    if (exp_b.size() > 0) begin
      e_b = exp_b.pop_front();
      check("sb_b{val,rise,fall,evr,evf}", 32'(o_b), 32'(e_b));
    end
    check("excl_a", 32'(bus_a.rise & bus_a.fall), 32'd0);
    check("excl_b", 32'(bus_b.rise & bus_b.fall), 32'd0);
  end

  // One clock edge: predict what the next edge produces, queue it, advance.
  task automatic tick();
    if (!reset_n) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, bus_a.pad, bus_a.ev_clr);
      model_step(1, bus_b.pad, bus_b.ev_clr);
    end
    exp_a.push_back(model_obs(0));
    exp_b.push_back(model_obs(1));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt_r, cnt_f, hi_cycles, first_hi, found, edge_no;
    int per[3];
    per = '{8, 13, 21};

    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++) begin
        m_rise_cnt[d][i]   = 0;
        dut_rise_cnt[d][i] = 0;
      end

    reset_n      = 1'b0;
    bus_a.pad    = RV_A;
    bus_a.ev_clr = '0;
    bus_b.pad    = RV_B;
    bus_b.ev_clr = '0;
    model_reset(0);
    model_reset(1);
    @(negedge clk);
    repeat (3) tick();

    // Idle pads at the reset level through release: no edges at all.
    reset_n = 1'b1;
    cnt_r = 0;
    cnt_f = 0;
    repeat (100) begin
      tick();
      cnt_r += $countones(bus_a.rise);
      cnt_f += $countones(bus_a.fall);
    end
    check("idle_val_a", 32'(bus_a.val), 32'(RV_A));
    check("idle_edges_a", 32'(cnt_r + cnt_f), 32'd0);

    // Unfiltered latency: val/rise at edge 3, sticky flag from edge 4.
    bus_a.pad = 3'b101;
    tick();
    tick();
    check("lat_e2_val0", 32'(bus_a.val[0]), 32'd0);
    tick();
    check("lat_e3_val0", 32'(bus_a.val[0]), 32'd1);
    check("lat_e3_rise0", 32'(bus_a.rise[0]), 32'd1);
    check("lat_e3_evr0", 32'(bus_a.ev_rise[0]), 32'd0);
    tick();
    check("lat_e4_rise0", 32'(bus_a.rise[0]), 32'd0);
    check("lat_e4_evr0", 32'(bus_a.ev_rise[0]), 32'd1);

    // FILTER_LEN=4: a 3-cycle glitch is swallowed.
    bus_b.pad = 3'b010;
    repeat (3) tick();
    bus_b.pad = 3'b000;
    repeat (12) begin
      tick();
      check("glitch_val1", 32'(bus_b.val[1]), 32'd0);
    end
    check("glitch_evr1", 32'(bus_b.ev_rise[1]), 32'd0);

    // A 4-cycle pulse passes: high for exactly 4 cycles starting at edge 6.
    bus_b.pad = 3'b010;
    hi_cycles = 0;
    first_hi  = 0;
    cnt_r     = 0;
    cnt_f     = 0;
    for (int t = 1; t <= 20; t++) begin
      if (t == 5) bus_b.pad = 3'b000;
      tick();
      if (bus_b.val[1]) begin
        hi_cycles++;
        if (first_hi == 0) first_hi = t;
      end
      cnt_r += int'(bus_b.rise[1]);
      cnt_f += int'(bus_b.fall[1]);
    end
    check("pulse_first_edge", 32'(first_hi), 32'd6);
    check("pulse_hi_cycles", 32'(hi_cycles), 32'd4);
    check("pulse_rise_cnt", 32'(cnt_r), 32'd1);
    check("pulse_fall_cnt", 32'(cnt_f), 32'd1);

    // Set and clear in the same cycle: set wins; a lone clear then drops it.
    bus_a.pad = 3'b001;
    repeat (5) tick();
    bus_a.pad = 3'b101;
    found = 0;
    for (int t = 0; t < 10 && found == 0; t++) begin
      tick();
      if (bus_a.rise[2]) found = 1;
    end
    check("clr_rise2_seen", 32'(found), 32'd1);
    bus_a.ev_clr = 3'b100;
    tick();
    check("clr_set_wins", 32'(bus_a.ev_rise[2]), 32'd1);
    tick();
    check("clr_alone", 32'(bus_a.ev_rise[2]), 32'd0);
    bus_a.ev_clr = 3'b000;

    // All channels toggling with different periods on both instances.
    for (int t = 0; t < 420; t++) begin
      for (int i = 0; i < 3; i++)
        if (t % per[i] == per[i] - 1) begin
          bus_a.pad[i] = ~bus_a.pad[i];
          bus_b.pad[i] = ~bus_b.pad[i];
        end
      tick();
    end
    repeat (10) tick();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 3; i++)
        check($sformatf("toggle_rise_cnt_d%0d_ch%0d", d, i),
              32'(dut_rise_cnt[d][i]), 32'(m_rise_cnt[d][i]));

    // Reset asserted two samples into a filtered transition.
    bus_a.pad = RV_A;
    bus_b.pad = 3'b000;
    repeat (12) tick();
    bus_b.pad = 3'b001;
    repeat (4) tick();
    check("midrst_pre_val0", 32'(bus_b.val[0]), 32'd0);
    reset_n = 1'b0;
    #1;
    check("midrst_async_a",
          32'({bus_a.val, bus_a.rise, bus_a.fall, bus_a.ev_rise, bus_a.ev_fall}),
          32'({RV_A, 12'd0}));
    check("midrst_async_b",
          32'({bus_b.val, bus_b.rise, bus_b.fall, bus_b.ev_rise, bus_b.ev_fall}),
          32'({RV_B, 12'd0}));
    @(negedge clk);
    repeat (2) tick();
    reset_n = 1'b1;
    edge_no = 0;
    cnt_r   = 0;
    for (int t = 1; t <= 20; t++) begin
      tick();
      cnt_r += int'(bus_b.rise[0]);
      if (edge_no == 0 && bus_b.val[0]) edge_no = t;
    end
    check("midrst_fresh_edge", 32'(edge_no), 32'(S_B + F_B));
    check("midrst_one_pulse", 32'(cnt_r), 32'd1);

    // Random pad noise with sticky pad bits and random clears.
    for (int t = 0; t < 20000; t++) begin
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(7) == 0) bus_a.pad[i] = ~bus_a.pad[i];
        if ($urandom_range(5) == 0) bus_b.pad[i] = ~bus_b.pad[i];
      end
      bus_a.ev_clr = 3'($urandom_range(7)) & {3{$urandom_range(3) == 0}};
      bus_b.ev_clr = 3'($urandom_range(7)) & {3{$urandom_range(3) == 0}};
      tick();
    end
    bus_a.ev_clr = '0;
    bus_b.ev_clr = '0;
    repeat (3) tick();
    check("drain_a", 32'(exp_a.size()), 32'd0);
    check("drain_b", 32'(exp_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
